// File: rtl/perm_pkg.sv
// Shared constants, rotation-amount type and lane-slicing helper for the
// write-side permutation pipeline.
package perm_pkg;

  localparam int unsigned LANES_DEF = 8;
  localparam int unsigned DW_DEF    = 64;
  localparam int unsigned RW_DEF    = $clog2(LANES_DEF);

  typedef logic [RW_DEF-1:0] rot_amt_t;

  // Bit offset of lane `lane` in a packed vector of `dw`-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/perm_rot.sv
// Combinational cyclic lane rotator: q lane i takes d lane (i - r) mod LANES.
module perm_rot
  import perm_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned RW    = $clog2(LANES)
) (
  input  logic [LANES*DW-1:0] d_i,
  input  logic [RW-1:0]       r_i,
  output logic [LANES*DW-1:0] q_o
);

  // LANES is a power of two, so RW-bit subtraction wraps modulo LANES.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [RW-1:0] src;
    assign src = RW'(i) - r_i;
    assign q_o[lane_lsb(i, DW) +: DW] = d_i[lane_lsb(32'(src), DW) +: DW];
  end

endmodule

// File: rtl/perm_write_pipe.sv
// Two-stage valid/ready pipeline: bank select then lane rotation for bank writes.
// Define PERM_WRITE_AUTO_ROT_EN to enable the auto-rotation counter.
module perm_write_pipe
  import perm_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned RW    = $clog2(LANES)
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                SEL_EXTN,
  input  logic [RW-1:0]       SEL_PERM,
  input  logic                AUTO_MODE,
  input  logic [RW-1:0]       ROT_STEP,
  input  logic                CNT_CLR,
  input  logic [LANES*DW-1:0] D_EXTN,
  input  logic [LANES*DW-1:0] D_HRMF,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [LANES*DW-1:0] Q,
  output logic [RW-1:0]       ROT_CNT
);

  localparam int unsigned BW = LANES * DW;

  logic          v1_q, v1_d, v2_q, v2_d;
  logic [BW-1:0] s1_data_q, s1_data_d;
  logic [RW-1:0] s1_rot_q, s1_rot_d;
  logic [BW-1:0] q_q, q_d, rot_out;
  logic [RW-1:0] rot_sel;
  logic          adv1, adv2, accept;

  assign adv2     = ~v2_q | OUT_READY;
  assign adv1     = ~v1_q | adv2;
  assign accept   = IN_VALID & adv1;
  assign IN_READY = adv1;

`ifdef PERM_WRITE_AUTO_ROT_EN
  logic [RW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the accepted beat still sees the pre-clear count.
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (accept && AUTO_MODE) begin
      cnt_d = cnt_q + ROT_STEP;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rot_sel = AUTO_MODE ? cnt_q : SEL_PERM;
  assign ROT_CNT = cnt_q;
`else
  logic unused_auto;
  assign unused_auto = ^{AUTO_MODE, ROT_STEP, CNT_CLR};
  assign rot_sel     = SEL_PERM;
  assign ROT_CNT     = '0;
`endif

  // Stage 1: bank select and rotation amount capture.
  always_comb begin
    v1_d      = v1_q;
    s1_data_d = s1_data_q;
    s1_rot_d  = s1_rot_q;
    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        s1_data_d = SEL_EXTN ? D_HRMF : D_EXTN;
        s1_rot_d  = rot_sel;
      end
    end
  end

  perm_rot #(
    .LANES (LANES),
    .DW    (DW),
    .RW    (RW)
  ) u_rot (
    .d_i (s1_data_q),
    .r_i (s1_rot_q),
    .q_o (rot_out)
  );

  // Stage 2: rotated result; data held through bubbles and stalls.
  always_comb begin
    v2_d = v2_q;
    q_d  = q_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        q_d = rot_out;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      s1_data_q <= '0;
      s1_rot_q  <= '0;
      q_q       <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      s1_data_q <= s1_data_d;
      s1_rot_q  <= s1_rot_d;
      q_q       <= q_d;
    end
  end

  assign OUT_VALID = v2_q;
  assign Q         = q_q;

endmodule

// File: tb/tb_perm_write_pipe.sv
// Scoreboard bench for perm_write_pipe plus a lane-count sweep of perm_rot.
`timescale 1ns/1ps
module tb_perm_write_pipe;

  localparam int unsigned LANES = 8;
  localparam int unsigned DW    = 64;
  localparam int unsigned RW    = $clog2(LANES);
  localparam int unsigned BW    = LANES * DW;
`ifdef PERM_WRITE_AUTO_ROT_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid, in_ready, sel_extn, auto_mode, cnt_clr;
  logic [RW-1:0] sel_perm, rot_step, rot_cnt;
  logic [BW-1:0] d_extn, d_hrmf, q;
  logic          out_valid, out_ready;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] sb_q[$];
  int cnt_m = 0;

  always #5 clk = ~clk;

  perm_write_pipe #(.LANES(LANES), .DW(DW)) dut (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready),
    .SEL_EXTN(sel_extn), .SEL_PERM(sel_perm), .AUTO_MODE(auto_mode),
    .ROT_STEP(rot_step), .CNT_CLR(cnt_clr), .D_EXTN(d_extn), .D_HRMF(d_hrmf),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .Q(q), .ROT_CNT(rot_cnt)
  );

  logic [4*16-1:0]  rd4, rq4;
  logic [1:0]       rr4;
  logic [16*32-1:0] rd16, rq16;
  logic [3:0]       rr16;
  perm_rot #(.LANES(4),  .DW(16)) u_rot4  (.d_i(rd4),  .r_i(rr4),  .q_o(rq4));
  perm_rot #(.LANES(16), .DW(32)) u_rot16 (.d_i(rd16), .r_i(rr16), .q_o(rq16));

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: output lane i is input lane (i - r) mod LANES.
  function automatic logic [BW-1:0] model_rot(input logic [BW-1:0] d, input int r);
    logic [DW-1:0] lanes_in[LANES];
    logic [BW-1:0] res;
    for (int i = 0; i < LANES; i++) lanes_in[i] = d[i*DW +: DW];
    for (int i = 0; i < LANES; i++) res[i*DW +: DW] = lanes_in[(i - r + LANES) % LANES];
    return res;
  endfunction

  task automatic rand_bw(output logic [BW-1:0] d);
    for (int i = 0; i < BW/32; i++) d[i*32 +: 32] = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs change only at posedge+1, so the negedge sees the values
  // that the next posedge will act on.
  always @(negedge clk) begin : mon
    int r;
    logic [RW-1:0] exp_cnt;
    if (rstn) begin
      exp_cnt = AUTO_EN ? RW'(cnt_m) : '0;
      chk("rot_cnt", BW'(rot_cnt), BW'(exp_cnt));
      chk("in_ready", BW'(in_ready), BW'((sb_q.size() < 2) || out_ready));
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", BW'(out_valid), BW'(0));
        end else begin
          chk("q", q, sb_q[0]);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        r = (AUTO_EN && auto_mode) ? cnt_m : int'(sel_perm);
        sb_q.push_back(model_rot(sel_extn ? d_hrmf : d_extn, r));
      end
      if (cnt_clr) cnt_m = 0;
      else if (in_valid && in_ready && auto_mode) cnt_m = (cnt_m + int'(rot_step)) % LANES;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded bound", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int tab1[10] = '{0, 3, 6, 1, 4, 7, 2, 5, 0, 3};
    int tab2[10] = '{0, 3, 6, 1, 4, 0, 3, 6, 1, 4};
    int guard;
    in_valid = 0; sel_extn = 0; sel_perm = '0; auto_mode = 0; rot_step = '0;
    cnt_clr = 0; d_extn = '0; d_hrmf = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_q", q, '0);
    chk("rst_rot_cnt", BW'(rot_cnt), BW'(0));
    rstn = 1;
    #1;
    chk("rst_in_ready", BW'(in_ready), BW'(1));

    // Single beat, lane i = i, rotate by 1.
    for (int i = 0; i < LANES; i++) d_extn[i*DW +: DW] = DW'(i);
    sel_extn = 0; sel_perm = RW'(1); in_valid = 1;
    step();
    in_valid = 0;
    chk("lat_edge1_valid", BW'(out_valid), BW'(0));
    step();
    chk("lat_edge2_valid", BW'(out_valid), BW'(1));
    for (int i = 0; i < LANES; i++)
      chk("single_lane", BW'(q[i*DW +: DW]), BW'((i + LANES - 1) % LANES));

    // Back-to-back streaming over every rotation amount.
    for (int k = 0; k < 8; k++) begin
      sel_perm = RW'(k); sel_extn = k[0];
      rand_bw(d_extn); rand_bw(d_hrmf); in_valid = 1;
      step();
    end
    in_valid = 0;
    repeat (3) step();

    // Backpressure mid-stream.
    for (int k = 0; k < 3; k++) begin
      sel_perm = RW'($urandom); sel_extn = 1'($urandom);
      rand_bw(d_extn); rand_bw(d_hrmf); in_valid = 1;
      step();
    end
    out_ready = 0;
    #1;
    chk("bp_in_ready_low", BW'(in_ready), BW'(0));
    repeat (4) step();
    out_ready = 1;
    #1;
    chk("bp_release_ready", BW'(in_ready), BW'(1));
    for (int k = 0; k < 3; k++) begin
      sel_perm = RW'($urandom); rand_bw(d_extn); rand_bw(d_hrmf);
      step();
    end
    in_valid = 0;
    repeat (3) step();

`ifdef PERM_WRITE_AUTO_ROT_EN
    cnt_clr = 1;
    step();
    cnt_clr = 0; auto_mode = 1; rot_step = RW'(3);
    for (int k = 0; k < 10; k++) begin
      chk("auto_seq", BW'(rot_cnt), BW'(tab1[k]));
      sel_perm = RW'($urandom); rand_bw(d_extn); in_valid = 1;
      step();
    end
    in_valid = 0; cnt_clr = 1;
    step();
    cnt_clr = 0;
    for (int k = 0; k < 10; k++) begin
      chk("auto_clr_seq", BW'(rot_cnt), BW'(tab2[k]));
      rand_bw(d_extn); in_valid = 1; cnt_clr = (k == 4);
      step();
    end
    in_valid = 0; cnt_clr = 0; auto_mode = 0;
    repeat (3) step();
`endif

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      sel_extn  = 1'($urandom);
      sel_perm  = RW'($urandom);
      auto_mode = 1'($urandom);
      rot_step  = RW'($urandom);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      rand_bw(d_extn); rand_bw(d_hrmf);
      step();
    end
    in_valid = 0; cnt_clr = 0; out_ready = 1;
    repeat (4) step();

    // Reset with both stages full.
    out_ready = 0; in_valid = 1; auto_mode = 1; rot_step = RW'(5);
    for (int k = 0; k < 3; k++) begin
      rand_bw(d_extn); sel_perm = RW'(k + 1);
      step();
    end
    chk("pre_rst_full", BW'(in_ready), BW'(0));
    rstn = 0; in_valid = 0; auto_mode = 0;
    #1;
    chk("midrst_out_valid", BW'(out_valid), BW'(0));
    chk("midrst_q", q, '0);
    chk("midrst_rot_cnt", BW'(rot_cnt), BW'(0));
    sb_q.delete();
    cnt_m = 0;
    step();
    rstn = 1; out_ready = 1;
    #1;
    chk("post_rst_in_ready", BW'(in_ready), BW'(1));
    for (int k = 0; k < 4; k++) begin
      sel_perm = RW'($urandom); sel_extn = 1'($urandom);
      rand_bw(d_extn); rand_bw(d_hrmf); in_valid = 1;
      step();
    end
    in_valid = 0;
    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("drain_empty", BW'(sb_q.size()), BW'(0));

    // Rotator sweep at other lane counts, including wrap at r = LANES-1.
    for (int t = 0; t < 6; t++) begin
      logic [4*16-1:0]  e4;
      logic [16*32-1:0] e16;
      int r4, r16;
      r4  = (t % 3 == 0) ? 3  : $urandom_range(0, 3);
      r16 = (t % 3 == 0) ? 15 : $urandom_range(0, 15);
      rd4 = {$urandom, $urandom};
      for (int i = 0; i < 16; i++) rd16[i*32 +: 32] = $urandom;
      rr4 = 2'(r4); rr16 = 4'(r16);
      #1;
      for (int i = 0; i < 4; i++)  e4[i*16 +: 16]  = rd4[((i - r4 + 4) % 4)*16 +: 16];
      for (int i = 0; i < 16; i++) e16[i*32 +: 32] = rd16[((i - r16 + 16) % 16)*32 +: 32];
      chk("rot4", BW'(rq4), BW'(e4));
      chk("rot16", BW'(rq16), BW'(e16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
